hilo_muldiv_ctrl: RTL
=====================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  EX-stage multiply/divide controller and HI/LO register owner. It decodes MULT/DIV/MTHI/MTLO/MFHI/MFLO
//  from ID/EX, runs the iterative divider through its start/ready/annul handshake, and stalls the pipeline
//  while a divide is in flight. It commits all results to the architectural HI/LO registers.
// PARAMETERS
//  OPW      4   width of op_i encoding
//  HILO_RST 0   reset value of HI and LO (32-bit each)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   synchronous reset, active-high
//  flush_i       in   1   pipeline flush; kills the in-flight op
//  stall_i       in   1   downstream stall; blocks every HI/LO commit
//  valid_i       in   1   op_i/rs_i/rt_i are valid this cycle
//  op_i          in   OPW 0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO,9 MADD,10 MADDU,11 MSUB,12 MSUBU
//  rs_i,rt_i     in   32  operands (dividend/multiplicand = rs)
//  div_start_o   out  1   divider start (1=start, 0=stop)
//  div_annul_o   out  1   divider annul
//  div_signed_o  out  1   1 for DIV
//  div_op1_o/op2_o out 32 divider operands, held stable while busy
//  div_result_i  in   64  {remainder,quotient}
//  div_ready_i   in   1   divider result valid
//  stall_o       out  1   stall request to pipeline control
//  hi_o,lo_o     out  32  architectural HI/LO
//  rdata_o       out  32  MFHI->hi_o, MFLO->lo_o, else 0 (combinational)
// BEHAVIOUR
//  - Reset: state=IDLE, hi_o=lo_o=HILO_RST. div_start_o, div_annul_o and stall_o are 0. Operand latches are 0.
//  - Single-cycle ops (MULT(U)/MTHI/MTLO): commit at the issue-cycle edge iff valid_i & ~stall_i & ~flush_i.
//    MULT: {HI,LO} = 64-bit signed product. MULTU: unsigned product. MTHI/MTLO write rs_i to one register.
//    These ops never raise stall_o.
//  - FSM states: IDLE and DIV_WAIT.
//    IDLE, valid DIV(U), ~flush_i:
//      - latch rs/rt/signed, go to DIV_WAIT.
//      - Same cycle: div_start_o=1, stall_o=1; div_op*_o driven from rs_i/rt_i (pass-through).
//    DIV_WAIT:
//      - div_start_o = ~div_ready_i.
//      - stall_o = ~(div_ready_i & ~stall_i).
//    DIV_WAIT, div_ready_i & ~stall_i:
//      - HI<=result[63:32], LO<=result[31:0].
//      - Drop start so the divider returns to free; go to IDLE.
//    DIV_WAIT, div_ready_i & stall_i: hold start=1, state and HI/LO. Divider keeps ready/result.
//    flush_i in DIV_WAIT: div_annul_o=1 and div_start_o=0 for that cycle. Go to IDLE, no HI/LO write.
//    flush_i in IDLE: op is ignored, start never rises.
//  - Latency: DIV occupies the divider about 36 cycles; stall_o stays high until the commit cycle.
//  - Divide by zero: divider returns 0; HI=LO=0 after about 3 cycles, no exception.
//  - The divider computes remainder sign from the dividend. Operand outputs stay constant while busy for this reason.
//  - rst mid-divide: FSM to IDLE, start/annul 0. Divider is reset by the same rst.
//  - MFHI/MFLO never stall: in-order issue plus stall_o guarantee HI/LO are final at read.
// CONFIGURATION
//  HILO_MADD_EN defined:
//    - ops 9-12 perform {HI,LO} <= {HI,LO} +/- product.
//    - Signed product for MADD/MSUB, unsigned for MADDU/MSUBU.
//    - Wraps mod 2^64; single cycle, same commit gating as MULT.
//  HILO_MADD_EN undefined: ops 9-12 behave as NOP and no accumulator adder is built.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> hi_o=lo_o=0, stall_o=0, div_start_o=0.
//  T2 MULT rs=-3 rt=7 -> next cycle HI=FFFFFFFF, LO=FFFFFFEB.
//     MULTU of same operands -> HI=00000006, LO=FFFFFFEB.
//  T3 DIV rs=-7 rt=2:
//     - stall_o high until commit.
//     - HI=FFFFFFFF, LO=FFFFFFFD within 40 cycles.
//     - div_start_o falls on the commit cycle.
//  T4 DIVU rs=100 rt=0 -> HI=0, LO=0, stall_o low within 5 cycles.
//  T5 DIV rs=9 rt=4, flush_i pulsed 10 cycles after issue:
//     - div_annul_o=1 for one cycle; state returns to IDLE.
//     - HI/LO unchanged.
//     - A following DIVU rs=9 rt=4 gives HI=1, LO=2.
//  T6 DIV with stall_i held 5 cycles after div_ready_i:
//     - no commit and start held during stall.
//     - Commit on the first ~stall_i cycle.
//  T7 (HILO_MADD_EN) HI/LO=0/5, MADDU rs=2 rt=3 -> HI=0, LO=B.
//     Then MSUB rs=1 rt=12 -> HI=FFFFFFFF, LO=FFFFFFFF.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - EX-stage multiply/divide controller and HI/LO register owner
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when HILO_MADD_EN is defined.
module hilo_muldiv_ctrl #(
  parameter int          OPW      = 4,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           stall_i,
  input  logic           valid_i,
  input  logic [OPW-1:0] op_i,
  input  logic [31:0]    rs_i,
  input  logic [31:0]    rt_i,
  output logic           div_start_o,
  output logic           div_annul_o,
  output logic           div_signed_o,
  output logic [31:0]    div_op1_o,
  output logic [31:0]    div_op2_o,
  input  logic [63:0]    div_result_i,
  input  logic           div_ready_i,
  output logic           stall_o,
  output logic [31:0]    hi_o,
  output logic [31:0]    lo_o,
  output logic [31:0]    rdata_o
);

  localparam logic [OPW-1:0] OP_MULT  = OPW'(1);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(2);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(4);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(5);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(6);
  localparam logic [OPW-1:0] OP_MFHI  = OPW'(7);
  localparam logic [OPW-1:0] OP_MFLO  = OPW'(8);
`ifdef HILO_MADD_EN
  localparam logic [OPW-1:0] OP_MADD  = OPW'(9);
  localparam logic [OPW-1:0] OP_MADDU = OPW'(10);
  localparam logic [OPW-1:0] OP_MSUB  = OPW'(11);
  localparam logic [OPW-1:0] OP_MSUBU = OPW'(12);
`endif

  typedef enum logic {S_IDLE, S_DIV_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] op1_q, op2_q;
  logic        signed_q;
  logic        div_issue, div_commit, sc_en, is_div;
  logic [63:0] prod_s, prod_u, hilo_q, hilo_d;

  assign hilo_q = {hi_o, lo_o};
  assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign sc_en  = (state_q == S_IDLE) && valid_i && !stall_i && !flush_i;

  assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign prod_u = {32'h0, rs_i} * {32'h0, rt_i};

`ifdef HILO_MADD_EN
  logic [63:0] acc_prod, acc_sum;
  always_comb begin
    acc_prod = ((op_i == OP_MADD) || (op_i == OP_MSUB)) ? prod_s : prod_u;
    acc_sum  = ((op_i == OP_MADD) || (op_i == OP_MADDU)) ? hilo_q + acc_prod
                                                         : hilo_q - acc_prod;
  end
`endif

  // Operands pass straight through on the issue cycle, then come from the latches
  // so the divider sees stable inputs for the whole divide.
  always_comb begin
    state_d      = state_q;
    div_start_o  = 1'b0;
    div_annul_o  = 1'b0;
    stall_o      = 1'b0;
    div_issue    = 1'b0;
    div_commit   = 1'b0;
    div_op1_o    = op1_q;
    div_op2_o    = op2_q;
    div_signed_o = signed_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && is_div && !flush_i) begin
          div_issue    = 1'b1;
          div_start_o  = 1'b1;
          stall_o      = 1'b1;
          div_op1_o    = rs_i;
          div_op2_o    = rt_i;
          div_signed_o = (op_i == OP_DIV);
          state_d      = S_DIV_WAIT;
        end
      end
      S_DIV_WAIT: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = S_IDLE;
        end else begin
          // Start stays up while a finished result is blocked by a downstream stall.
          div_start_o = !(div_ready_i && !stall_i);
          stall_o     = !(div_ready_i && !stall_i);
          if (div_ready_i && !stall_i) begin
            div_commit = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      div_start_o = 1'b0;
      div_annul_o = 1'b0;
      stall_o     = 1'b0;
      div_issue   = 1'b0;
      div_commit  = 1'b0;
    end
  end

  always_comb begin
    hilo_d = hilo_q;
    if (div_commit) begin
      hilo_d = div_result_i;
    end else if (sc_en) begin
      case (op_i)
        OP_MULT:  hilo_d = prod_s;
        OP_MULTU: hilo_d = prod_u;
        OP_MTHI:  hilo_d = {rs_i, lo_o};
        OP_MTLO:  hilo_d = {hi_o, rs_i};
`ifdef HILO_MADD_EN
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: hilo_d = acc_sum;
`endif
        default:  hilo_d = hilo_q;
      endcase
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    if (op_i == OP_MFHI) rdata_o = hi_o;
    else if (op_i == OP_MFLO) rdata_o = lo_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_o     <= HILO_RST;
      lo_o     <= HILO_RST;
      op1_q    <= 32'h0;
      op2_q    <= 32'h0;
      signed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_o    <= hilo_d[63:32];
      lo_o    <= hilo_d[31:0];
      if (div_issue) begin
        op1_q    <= rs_i;
        op2_q    <= rt_i;
        signed_q <= (op_i == OP_DIV);
      end
    end
  end

endmodule
